// File: rtl/gauss_sample_fifo_if.sv
// Handshake bundle between the Box-Muller multiplier/consumer side and the
// Gaussian sample output FIFO.
interface gauss_sample_fifo_if #(
    parameter int OUT_W = 16,
    parameter int AW    = 3
);
    logic             mul_in_valid;
    logic [31:0]      mul_y;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [AW:0]      fifo_count;
    logic             overflow;
    logic [15:0]      drop_count;
    logic [15:0]      sat_count;

    modport master (
        output mul_in_valid, mul_y, out_ready,
        input  out_data, out_valid, fifo_count, overflow, drop_count, sat_count
    );

    modport slave (
        input  mul_in_valid, mul_y, out_ready,
        output out_data, out_valid, fifo_count, overflow, drop_count, sat_count
    );
endinterface

// File: rtl/gauss_sample_fifo.sv
// Box-Muller output stage: tracks multiplier latency, rounds/saturates the
// 32-bit product to OUT_W bits and buffers samples in a DEPTH-entry FIFO.
module gauss_sample_fifo #(
    parameter int MUL_LAT = 5,
    parameter int SHIFT   = 16,
    parameter int OUT_W   = 16,
    parameter int DEPTH   = 8,
    parameter int AW      = 3
) (
    input  logic                clk,
    input  logic                reset,
    gauss_sample_fifo_if.slave  bus
);
    localparam logic signed [32:0] RND_K = 33'sd1 <<< (SHIFT - 1);
    localparam logic signed [32:0] MAX_V = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
    localparam logic signed [32:0] MIN_V = -(33'sd1 <<< (OUT_W - 1));
    localparam logic [AW:0]        FULL_N = (AW + 1)'(DEPTH);

    logic [MUL_LAT-1:0] vld_q, vld_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [15:0]        sat_cnt_q, sat_cnt_d;
    logic [OUT_W-1:0]   mem [DEPTH];

    logic signed [32:0] rnd, q;
    logic [OUT_W-1:0]   sample;
    logic               clip, push, pop, wr_en, drop, empty, full;

    // Round half toward +inf, then clamp to the signed OUT_W range.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rnd    = $signed({bus.mul_y[31], bus.mul_y}) + RND_K;
        q      = rnd >>> SHIFT;
        clip   = 1'b0;
        sample = q[OUT_W-1:0];
        if (q > MAX_V) begin
            sample = MAX_V[OUT_W-1:0];
            clip   = 1'b1;
        end else if (q < MIN_V) begin
            sample = MIN_V[OUT_W-1:0];
            clip   = 1'b1;
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_N);
    assign push  = vld_q[MUL_LAT-1];
    assign pop   = !empty && bus.out_ready;
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        vld_d      = vld_q << 1;
        vld_d[0]   = bus.mul_in_valid;
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (wr_en && !pop)      count_d = count_q + 1'b1;
        else if (!wr_en && pop) count_d = count_q - 1'b1;
        ovf_d      = ovf_q | drop;
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        sat_cnt_d  = (push && clip && sat_cnt_q != 16'hFFFF) ? sat_cnt_q + 16'd1 : sat_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state always uses non-blocking assignments.
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            sat_cnt_q  <= '0;
        end else begin
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    // NOTE: storage is deliberately left unreset; empty gating hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= sample;
    end

    assign bus.out_data   = empty ? '0 : mem[rd_ptr_q];
    assign bus.out_valid  = !empty;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = ovf_q;
    assign bus.drop_count = drop_cnt_q;
    assign bus.sat_count  = sat_cnt_q;
endmodule

// File: tb/tb_gauss_sample_fifo.sv
// Self-checking bench for gauss_sample_fifo: table vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_gauss_sample_fifo;
    localparam int MUL_LAT = 5;
    localparam int SHIFT   = 16;
    localparam int OUT_W   = 16;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gauss_sample_fifo_if #(.OUT_W(OUT_W), .AW(AW)) bus ();

    gauss_sample_fifo #(
        .MUL_LAT(MUL_LAT), .SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] p;
    } flight_t;

    typedef struct {
        logic [31:0] y;
        logic [15:0] exp_data;
        logic [15:0] exp_sat;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: in-flight products with due cycle, FIFO as a queue.
    logic [15:0] m_fifo[$];
    flight_t     m_fl[$];
    logic        m_ovf;
    int          m_drop, m_sat;
    int          cyc;
    logic [31:0] mul_pipe[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_sample(input logic [31:0] y, output bit clip);
        longint v, q;
        logic [15:0] s;
        v    = longint'($signed(y));
        q    = (v + 32768) >>> 16;
        clip = 1'b0;
        if (q > 32767) begin
            s = 16'h7FFF; clip = 1'b1;
        end else if (q < -32768) begin
            s = 16'h8000; clip = 1'b1;
        end else begin
            s = q[15:0];
        end
        return s;
    endfunction

    // Compare outputs (state after last posedge), advance model by one posedge, drive inputs.
    task automatic step(input bit v, input logic [31:0] p, input bit rdy);
        bit          arrive, pop, clip;
        logic [15:0] s;
        logic [31:0] prod;
        @(negedge clk);
        check("out_valid",  bus.out_valid,  32'(m_fifo.size() != 0));
        check("out_data",   bus.out_data,   m_fifo.size() != 0 ? 32'(m_fifo[0]) : 32'h0);
        check("fifo_count", bus.fifo_count, 32'(m_fifo.size()));
        check("overflow",   bus.overflow,   32'(m_ovf));
        check("drop_count", bus.drop_count, 32'(m_drop));
        check("sat_count",  bus.sat_count,  32'(m_sat));

        arrive = (m_fl.size() > 0) && (m_fl[0].due == cyc);
        pop    = (m_fifo.size() > 0) && rdy;
        if (pop) void'(m_fifo.pop_front());
        if (arrive) begin
            prod = m_fl.pop_front().p;
            s    = to_sample(prod, clip);
            if (clip && m_sat < 16'hFFFF) m_sat++;
            if (m_fifo.size() < DEPTH) m_fifo.push_back(s);
            else begin
                m_ovf = 1'b1;
                if (m_drop < 16'hFFFF) m_drop++;
            end
        end
        if (v) m_fl.push_back('{due: cyc + MUL_LAT, p: p});

        mul_pipe.push_back(v ? p : $urandom);
        bus.mul_y        = mul_pipe.pop_front();
        bus.mul_in_valid = v;
        bus.out_ready    = rdy;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset            = 1'b1;
        bus.mul_in_valid = 1'b0;
        bus.out_ready    = 1'b0;
        m_fifo.delete();
        m_fl.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        m_sat  = 0;
        @(negedge clk);
        check("rst out_valid",  bus.out_valid,  0);
        check("rst out_data",   bus.out_data,   0);
        check("rst fifo_count", bus.fifo_count, 0);
        check("rst overflow",   bus.overflow,   0);
        check("rst drop_count", bus.drop_count, 0);
        check("rst sat_count",  bus.sat_count,  0);
        reset = 1'b0;
        cyc++;
    endtask

    vec_t vt[4];
    int   pops;
    int   drop_before;

    initial begin
        vt[0] = '{y: 32'h1234_8000, exp_data: 16'h1235, exp_sat: 16'd0};
        vt[1] = '{y: 32'h7FFF_8000, exp_data: 16'h7FFF, exp_sat: 16'd1};
        vt[2] = '{y: 32'hFFFF_7FFF, exp_data: 16'hFFFF, exp_sat: 16'd0};
        vt[3] = '{y: 32'h8000_0000, exp_data: 16'h8000, exp_sat: 16'd0};

        reset            = 1'b1;
        bus.mul_in_valid = 1'b0;
        bus.mul_y        = '0;
        bus.out_ready    = 1'b0;
        cyc              = 0;
        for (int i = 0; i < MUL_LAT; i++) mul_pipe.push_back($urandom);

        // Single-pulse latency, rounding and saturation vectors.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            step(1'b1, vt[i].y, 1'b0);
            for (int j = 0; j < MUL_LAT; j++) step(1'b0, $urandom, 1'b0);
            check("lat out_valid low", bus.out_valid, 0);
            step(1'b0, $urandom, 1'b0);
            check("lat out_valid high", bus.out_valid, 1);
            check("vec out_data", bus.out_data, 32'(vt[i].exp_data));
            check("vec sat_count", bus.sat_count, 32'(vt[i].exp_sat));
        end

        // Overflow: 10 back-to-back products into a stalled FIFO, then drain in order.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, (i + 1) << 16, 1'b0);
        for (int i = 0; i < MUL_LAT + 1; i++) step(1'b0, $urandom, 1'b0);
        check("ovf fifo_count", bus.fifo_count, 8);
        check("ovf drop_count", bus.drop_count, 2);
        check("ovf overflow",   bus.overflow,   1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, $urandom, 1'b1);
            check("drain order", bus.out_data, 32'(i + 1));
        end
        step(1'b0, $urandom, 1'b0);
        check("drain empty", bus.out_valid, 0);

        // Full FIFO with simultaneous push and pop.
        drop_before = m_drop;
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, (i + 20) << 16, 1'b0);
        for (int i = 0; i < MUL_LAT - 1; i++) step(1'b0, $urandom, 1'b0);
        step(1'b0, $urandom, 1'b1);
        step(1'b0, $urandom, 1'b0);
        check("full pp fifo_count", bus.fifo_count, 8);
        check("full pp drop_count", bus.drop_count, 32'(drop_before));
        check("full pp head", bus.out_data, 32'd21);

        // Streaming with continuous ready across pointer wrap.
        do_reset();
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, $urandom, 1'b1);
            if (bus.out_valid) pops++;
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, $urandom, 1'b1);
            if (bus.out_valid) pops++;
        end
        check("stream pops", 32'(pops), 20);
        check("stream drops", bus.drop_count, 0);

        // Reset with 4 stored and 3 in flight.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0);
        for (int i = 0; i < MUL_LAT; i++) step(1'b0, $urandom, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
        check("pre-reset fifo_count", bus.fifo_count, 4);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, $urandom, 1'b1);
        check("post-reset out_valid", bus.out_valid, 0);
        check("post-reset fifo_count", bus.fifo_count, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] y;
            y = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 32'h00FF_FFFF)) - 32'sh0080_0000) << 8;
            step($urandom_range(0, 9) < 7, y, $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 20; i++) step(1'b0, $urandom, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
